// File: rtl/dispatch_sb.sv
// dispatch_sb: N-wide in-order dispatch stage between decode and EXE.
//   - Resolves source operands through a prioritised forwarding network
//     (port 0 = youngest); register 0 always reads as zero.
//   - Issues the longest hazard-free in-order prefix of the decode group.
//   - Tracks outstanding loads with a per-register countdown scoreboard.
//   - Registers issued slots into an EXE-facing pipeline register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             backend stall (hold) / pipeline flush (clear)
//   id_*                     decode group, one entry per slot
//   rf_rd_*                  regfile read request (comb) and same-cycle data
//   fwd_*                    forwarding sources
//   ib_accept_o, stallreq_o  slots consumed this cycle / head slot blocked
//   exe_*                    registered issue results, one entry per slot
// Optional feature macro: BRANCH_PRECOMP_EN adds exe_cmp_o, a registered
//   {geu, ltu, ge_s, lt_s, ne, eq} comparison of resolved rs1 vs rs2.
module dispatch_sb #(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned FWD_PORTS   = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned LOAD_LAT    = 2,
  parameter int unsigned PAYLOAD_W   = 64,
  localparam int unsigned RA         = $clog2(NUM_REGS),
  localparam int unsigned NSRC       = ISSUE_WIDTH * 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic                            flush,
  input  logic [ISSUE_WIDTH-1:0]          id_valid,
  input  logic [NSRC-1:0]                 id_rs_valid,
  input  logic [NSRC*RA-1:0]              id_rs_addr,
  input  logic [ISSUE_WIDTH-1:0]          id_rd_valid,
  input  logic [ISSUE_WIDTH*RA-1:0]       id_rd_addr,
  input  logic [ISSUE_WIDTH-1:0]          id_is_load,
  input  logic [ISSUE_WIDTH-1:0]          id_use_imm,
  input  logic [ISSUE_WIDTH*DATA_W-1:0]   id_imm,
  input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] id_payload,
  output logic [NSRC-1:0]                 rf_rd_valid_o,
  output logic [NSRC*RA-1:0]              rf_rd_addr_o,
  input  logic [NSRC*DATA_W-1:0]          rf_rd_data_i,
  input  logic [FWD_PORTS-1:0]            fwd_valid,
  input  logic [FWD_PORTS*RA-1:0]         fwd_addr,
  input  logic [FWD_PORTS*DATA_W-1:0]     fwd_data,
  output logic [ISSUE_WIDTH-1:0]          ib_accept_o,
  output logic                            stallreq_o,
  output logic [ISSUE_WIDTH-1:0]          exe_valid_o,
  output logic [ISSUE_WIDTH*DATA_W-1:0]   exe_op1_o,
  output logic [ISSUE_WIDTH*DATA_W-1:0]   exe_op2_o,
  output logic [ISSUE_WIDTH-1:0]          exe_rd_valid_o,
  output logic [ISSUE_WIDTH*RA-1:0]       exe_rd_addr_o,
  output logic [ISSUE_WIDTH-1:0]          exe_is_load_o,
  output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] exe_payload_o
`ifdef BRANCH_PRECOMP_EN
  ,
  output logic [ISSUE_WIDTH*6-1:0]        exe_cmp_o
`endif
);

  localparam int unsigned CNT_W = 3;

  logic [RA-1:0]      rs_addr [NSRC];
  logic [RA-1:0]      rd_addr [ISSUE_WIDTH];
  logic [DATA_W-1:0]  src_val [NSRC];
  logic               fwd_hit;
  logic [NSRC-1:0]    src_haz;
  logic [ISSUE_WIDTH-1:0] issue;
  logic               prefix_ok;

  logic [CNT_W-1:0]   sb_q [NUM_REGS];
  logic [CNT_W-1:0]   sb_d [NUM_REGS];

  logic [ISSUE_WIDTH-1:0]           exe_valid_q,    exe_valid_d;
  logic [ISSUE_WIDTH*DATA_W-1:0]    exe_op1_q,      exe_op1_d;
  logic [ISSUE_WIDTH*DATA_W-1:0]    exe_op2_q,      exe_op2_d;
  logic [ISSUE_WIDTH-1:0]           exe_rd_valid_q, exe_rd_valid_d;
  logic [ISSUE_WIDTH*RA-1:0]        exe_rd_addr_q,  exe_rd_addr_d;
  logic [ISSUE_WIDTH-1:0]           exe_is_load_q,  exe_is_load_d;
  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] exe_payload_q,  exe_payload_d;
`ifdef BRANCH_PRECOMP_EN
  logic [ISSUE_WIDTH*6-1:0]         exe_cmp_q,      exe_cmp_d;
  logic [ISSUE_WIDTH*6-1:0]         cmp_c;
`endif

  // Regfile read request is a straight passthrough of the decode sources.
  assign rf_rd_valid_o = id_rs_valid;
  assign rf_rd_addr_o  = id_rs_addr;

  // Unpack address fields for readability.
  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      rs_addr[s] = id_rs_addr[s*RA +: RA];
    end
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      rd_addr[i] = id_rd_addr[i*RA +: RA];
    end
  end

  // Operand resolution: r0 -> 0, else lowest matching fwd port, else regfile.
  always_comb begin
    fwd_hit = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      src_val[s] = rf_rd_data_i[s*DATA_W +: DATA_W];
      fwd_hit    = 1'b0;
      if (id_rs_valid[s]) begin
        for (int unsigned p = 0; p < FWD_PORTS; p++) begin
          if (!fwd_hit && fwd_valid[p] && (fwd_addr[p*RA +: RA] == rs_addr[s])) begin
            src_val[s] = fwd_data[p*DATA_W +: DATA_W];
            fwd_hit    = 1'b1;
          end
        end
        if (rs_addr[s] == '0) begin
          src_val[s] = '0;
        end
      end
    end
  end

  // Per-source hazard: pending load in the scoreboard or RAW on an older slot.
  always_comb begin
    src_haz = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (id_rs_valid[s] && (rs_addr[s] != '0)) begin
        if (sb_q[rs_addr[s]] != '0) begin
          src_haz[s] = 1'b1;
        end
        for (int unsigned k = 0; k < s / 2; k++) begin
          if (id_valid[k] && id_rd_valid[k] && (rd_addr[k] == rs_addr[s])) begin
            src_haz[s] = 1'b1;
          end
        end
      end
    end
  end

  // Issue the in-order hazard-free prefix of the group.
  always_comb begin
    issue     = '0;
    prefix_ok = 1'b1;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      issue[i]  = prefix_ok && id_valid[i] && !src_haz[2*i] && !src_haz[2*i+1];
      prefix_ok = issue[i];
    end
  end

  assign ib_accept_o = issue & {ISSUE_WIDTH{!stall && !flush}};
  assign stallreq_o  = id_valid[0] && !issue[0];

  // Scoreboard next state: decrement, then set issued loads (later slot wins).
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = sb_q[r];
      if (!stall && (sb_q[r] != '0)) begin
        sb_d[r] = sb_q[r] - CNT_W'(1);
      end
    end
    if (!stall) begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
        if (issue[i] && id_is_load[i] && id_rd_valid[i] && (rd_addr[i] != '0)) begin
          sb_d[rd_addr[i]] = CNT_W'(LOAD_LAT);
        end
      end
    end
    if (flush) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        sb_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (rst) begin
        sb_q[r] <= '0;
      end else begin
        sb_q[r] <= sb_d[r];
      end
    end
  end

`ifdef BRANCH_PRECOMP_EN
  // Branch pre-compare on resolved sources, ahead of the immediate mux.
  always_comb begin
    cmp_c = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      cmp_c[i*6 + 0] = (src_val[2*i] == src_val[2*i+1]);
      cmp_c[i*6 + 1] = (src_val[2*i] != src_val[2*i+1]);
      cmp_c[i*6 + 2] = ($signed(src_val[2*i]) <  $signed(src_val[2*i+1]));
      cmp_c[i*6 + 3] = ($signed(src_val[2*i]) >= $signed(src_val[2*i+1]));
      cmp_c[i*6 + 4] = (src_val[2*i] <  src_val[2*i+1]);
      cmp_c[i*6 + 5] = (src_val[2*i] >= src_val[2*i+1]);
    end
  end
`endif

  // EXE register next state: flush clears, stall holds, else capture or bubble.
  always_comb begin
    exe_valid_d    = exe_valid_q;
    exe_op1_d      = exe_op1_q;
    exe_op2_d      = exe_op2_q;
    exe_rd_valid_d = exe_rd_valid_q;
    exe_rd_addr_d  = exe_rd_addr_q;
    exe_is_load_d  = exe_is_load_q;
    exe_payload_d  = exe_payload_q;
`ifdef BRANCH_PRECOMP_EN
    exe_cmp_d      = exe_cmp_q;
`endif
    if (flush) begin
      exe_valid_d    = '0;
      exe_op1_d      = '0;
      exe_op2_d      = '0;
      exe_rd_valid_d = '0;
      exe_rd_addr_d  = '0;
      exe_is_load_d  = '0;
      exe_payload_d  = '0;
`ifdef BRANCH_PRECOMP_EN
      exe_cmp_d      = '0;
`endif
    end else if (!stall) begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
        exe_valid_d[i]                        = issue[i];
        exe_op1_d[i*DATA_W +: DATA_W]         = issue[i] ? src_val[2*i] : '0;
        exe_op2_d[i*DATA_W +: DATA_W]         = !issue[i]     ? '0 :
                                                id_use_imm[i] ? id_imm[i*DATA_W +: DATA_W] :
                                                                src_val[2*i+1];
        exe_rd_valid_d[i]                     = issue[i] && id_rd_valid[i];
        exe_rd_addr_d[i*RA +: RA]             = issue[i] ? rd_addr[i] : '0;
        exe_is_load_d[i]                      = issue[i] && id_is_load[i];
        exe_payload_d[i*PAYLOAD_W +: PAYLOAD_W] = issue[i] ? id_payload[i*PAYLOAD_W +: PAYLOAD_W] : '0;
`ifdef BRANCH_PRECOMP_EN
        exe_cmp_d[i*6 +: 6]                   = issue[i] ? cmp_c[i*6 +: 6] : '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid_q    <= '0;
      exe_op1_q      <= '0;
      exe_op2_q      <= '0;
      exe_rd_valid_q <= '0;
      exe_rd_addr_q  <= '0;
      exe_is_load_q  <= '0;
      exe_payload_q  <= '0;
`ifdef BRANCH_PRECOMP_EN
      exe_cmp_q      <= '0;
`endif
    end else begin
      exe_valid_q    <= exe_valid_d;
      exe_op1_q      <= exe_op1_d;
      exe_op2_q      <= exe_op2_d;
      exe_rd_valid_q <= exe_rd_valid_d;
      exe_rd_addr_q  <= exe_rd_addr_d;
      exe_is_load_q  <= exe_is_load_d;
      exe_payload_q  <= exe_payload_d;
`ifdef BRANCH_PRECOMP_EN
      exe_cmp_q      <= exe_cmp_d;
`endif
    end
  end

  assign exe_valid_o    = exe_valid_q;
  assign exe_op1_o      = exe_op1_q;
  assign exe_op2_o      = exe_op2_q;
  assign exe_rd_valid_o = exe_rd_valid_q;
  assign exe_rd_addr_o  = exe_rd_addr_q;
  assign exe_is_load_o  = exe_is_load_q;
  assign exe_payload_o  = exe_payload_q;
`ifdef BRANCH_PRECOMP_EN
  assign exe_cmp_o      = exe_cmp_q;
`endif

endmodule
